if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage. Issues at most one instruction-memory request at a
//   time, tracks redirects (taken branches/jumps) and presents fetched packets
//   {pc, pc+4, instr} to the IF/ID register with valid/flush qualifiers.
//
//   Ports
//     clk, rst            : clock, asynchronous active-high reset
//     id_stall            : IF/ID holds this cycle; current packet not consumed
//     redirect            : redirect request, redirect_pc gives the target
//     redirect_pc         : target PC (low two bits ignored)
//     im_req, im_addr     : memory request and word address (held until ack)
//     im_ack, im_rdata    : memory response, data valid with the ack
//     pc_out, pcadd4_out,
//     instr_out           : fetched packet
//     if_valid            : packet valid this cycle
//     if_flush            : IF/ID must load a bubble this cycle
//
//   Build option
//     IF_FETCH_BUF_EN     : adds a one-entry skid buffer behind the output
//                           slot so one extra fetch can land during id_stall.
// -----------------------------------------------------------------------------
module if_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] pcadd4_out,
    output logic [31:0] instr_out,
    output logic        if_valid,
    output logic        if_flush
);
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;          // next PC to fetch (redirect target while discarding)
    logic [31:0] addr_q, addr_d;      // address of the request in flight
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic [31:0] out_instr_q, out_instr_d;

    logic [31:0] target_pc;
    logic [31:0] addr_plus4;
    logic        consume;
    logic        ack_data;
    logic        buf_occ;
    logic [1:0]  occ_after;           // packets held after this cycle's consume
    logic        slot_free;
    logic        refill_free;

`ifdef IF_FETCH_BUF_EN
    localparam logic [1:0] CAPACITY = 2'd2;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    assign buf_occ = buf_valid_q;
`else
    localparam logic [1:0] CAPACITY = 2'd1;
    assign buf_occ = 1'b0;
`endif

    assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign addr_plus4 = addr_q + 32'd4;
    assign consume    = out_valid_q & ~id_stall;
    assign ack_data   = (state_q == REQ) & im_ack;
    assign occ_after  = {1'b0, out_valid_q} + {1'b0, buf_occ} - {1'b0, consume};
    // Room for one more packet once this cycle's consume has happened.
    assign slot_free  = occ_after < CAPACITY;
    // Room for yet another packet after the one being acked this cycle.
    assign refill_free = (occ_after + 2'd1) < CAPACITY;

    // Request / PC sequencing
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    state_d = REQ;
                    pc_d    = target_pc;
                    addr_d  = target_pc;
                end else if (slot_free) begin
                    state_d = REQ;
                    addr_d  = pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_d = target_pc;
                    if (im_ack) begin
                        // Response dropped; restart immediately at the target.
                        state_d = REQ;
                        addr_d  = target_pc;
                    end else begin
                        // Address must stay on the bus until the stale ack.
                        state_d = DISCARD;
                    end
                end else if (im_ack) begin
                    pc_d    = addr_plus4;
                    addr_d  = addr_plus4;
                    state_d = refill_free ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_d = target_pc;
                end
                if (im_ack) begin
                    state_d = REQ;
                    addr_d  = redirect ? target_pc : pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output slot (and optional skid buffer)
    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_pc4_d   = out_pc4_q;
        out_instr_d = out_instr_q;
`ifdef IF_FETCH_BUF_EN
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_pc4_d   = buf_pc4_q;
        buf_instr_d = buf_instr_q;
`endif
        if (redirect) begin
            out_valid_d = 1'b0;
`ifdef IF_FETCH_BUF_EN
            buf_valid_d = 1'b0;
`endif
        end else if (out_valid_q && id_stall) begin
`ifdef IF_FETCH_BUF_EN
            // Output frozen; a landing response parks in the buffer.
            if (ack_data) begin
                buf_valid_d = 1'b1;
                buf_pc_d    = addr_q;
                buf_pc4_d   = addr_plus4;
                buf_instr_d = im_rdata;
            end
`endif
        end else begin
            out_valid_d = ack_data;
            if (ack_data) begin
                out_pc_d    = addr_q;
                out_pc4_d   = addr_plus4;
                out_instr_d = im_rdata;
            end
`ifdef IF_FETCH_BUF_EN
            buf_valid_d = 1'b0;
            if (buf_valid_q) begin
                // Older buffered packet goes first; a new ack takes its place.
                out_valid_d = 1'b1;
                out_pc_d    = buf_pc_q;
                out_pc4_d   = buf_pc4_q;
                out_instr_d = buf_instr_q;
                buf_valid_d = ack_data;
                if (ack_data) begin
                    buf_pc_d    = addr_q;
                    buf_pc4_d   = addr_plus4;
                    buf_instr_d = im_rdata;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= 32'd0;
            addr_q      <= 32'd0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'd0;
            out_pc4_q   <= 32'd0;
            out_instr_q <= 32'd0;
`ifdef IF_FETCH_BUF_EN
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 32'd0;
            buf_pc4_q   <= 32'd0;
            buf_instr_q <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_pc4_q   <= out_pc4_d;
            out_instr_q <= out_instr_d;
`ifdef IF_FETCH_BUF_EN
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_pc4_q   <= buf_pc4_d;
            buf_instr_q <= buf_instr_d;
`endif
        end
    end

    assign im_req     = (state_q != IDLE);
    assign im_addr    = addr_q;
    assign pc_out     = out_pc_q;
    assign pcadd4_out = out_pc4_q;
    assign instr_out  = out_instr_q;
    assign if_valid   = out_valid_q;
    assign if_flush   = redirect | ~out_valid_q;

endmodule
